// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN datapath blocks.
// sat_add is only referenced when NEURON_MAC_SAT_EN is defined.
package cnn_pkg;

  typedef enum logic [1:0] {
    ACCUM,
    DRAIN,
    OUTPUT
  } state_t;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int ACC_WIDTH      = 2 * DATA_WIDTH_DEF;
  localparam int SAT_MAXW       = 64;

  typedef struct packed {
    logic                ovf;
    logic [SAT_MAXW-1:0] sum;
  } sat_res_t;

  // Operands arrive sign-extended; overflow is judged at bit w-1.
  function automatic sat_res_t sat_add(
    input logic [SAT_MAXW-1:0] a,
    input logic [SAT_MAXW-1:0] b,
    input int                  w
  );
    sat_res_t            r;
    logic [SAT_MAXW-1:0] mx;
    logic                sa;
    logic                sb;
    logic                ss;
    mx    = (SAT_MAXW'(1) << (w - 1)) - SAT_MAXW'(1);
    r.sum = a + b;
    sa    = a[w-1];
    sb    = b[w-1];
    ss    = r.sum[w-1];
    r.ovf = (sa == sb) && (ss != sa);
    if (r.ovf) r.sum = sa ? ~mx : mx;
    return r;
  endfunction

endpackage

// File: rtl/neuron_mac_mult.sv
// Registered signed DW x DW multiplier with a valid/first-beat pipe.
module neuron_mac_mult #(
  parameter int DW = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_first,
  input  logic signed [DW-1:0]   a,
  input  logic signed [DW-1:0]   b,
  output logic                   out_valid,
  output logic                   out_first,
  output logic signed [2*DW-1:0] prod
);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
      prod      <= '0;
    end else begin
      out_valid <= in_valid;
      out_first <= in_valid & in_first;
      if (in_valid) prod <= (2*DW)'(a) * (2*DW)'(b);
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// Streaming MAC front end of one neuron window: bias + sum(data*weight).
// Define NEURON_MAC_SAT_EN for saturating adds with a sticky overflow flag.
module neuron_mac
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH       = DATA_WIDTH_DEF,
  parameter int WEIGHT_INT_WIDTH = 4,
  parameter int NUM_INPUTS       = 25
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic [DATA_WIDTH-1:0]     in_weight,
  input  logic [2*DATA_WIDTH-1:0]   bias,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*DATA_WIDTH-1:0]   out_acc,
  output logic                      out_ovf
);

  localparam int ACC_W = 2 * DATA_WIDTH;
  localparam int CNT_W = $clog2(NUM_INPUTS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_INPUTS - 1);

  if (NUM_INPUTS < 2 || WEIGHT_INT_WIDTH < 1 ||
      WEIGHT_INT_WIDTH > DATA_WIDTH) begin : g_bad_cfg
    $error("neuron_mac: bad parameters");
  end

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   beat_cnt;
  logic [ACC_W-1:0]   bias_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   prod_q;
  logic [ACC_W-1:0]   add_a;
  logic [ACC_W-1:0]   add_sum;
  logic               prod_vld_q;
  logic               prod_first_q;
  logic               out_valid_q;
  logic               take;
  logic               give;

  assign in_ready  = !rst && (state == ACCUM);
  assign take      = in_valid & in_ready;
  assign give      = out_valid_q & out_ready;
  assign out_valid = out_valid_q;
  assign out_acc   = acc_q;

  neuron_mac_mult #(
    .DW (DATA_WIDTH)
  ) u_mult (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (take),
    .in_first  (beat_cnt == '0),
    .a         (in_data),
    .b         (in_weight),
    .out_valid (prod_vld_q),
    .out_first (prod_first_q),
    .prod      (prod_q)
  );

  // First product of a window starts from the latched bias.
  assign add_a = prod_first_q ? bias_q : acc_q;

`ifdef NEURON_MAC_SAT_EN
  sat_res_t sat_r;
  logic     add_ovf;
  logic     ovf_q;

  always_comb begin
    sat_r   = sat_add(SAT_MAXW'($signed(add_a)),
                      SAT_MAXW'($signed(prod_q)), ACC_W);
    add_sum = sat_r.sum[ACC_W-1:0];
    add_ovf = sat_r.ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (give) begin
      ovf_q <= 1'b0;
    end else if (prod_vld_q) begin
      ovf_q <= ovf_q | add_ovf;
    end
  end

  assign out_ovf = ovf_q;
`else
  assign add_sum = add_a + prod_q;
  assign out_ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ACCUM;
      beat_cnt    <= '0;
      bias_q      <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        beat_cnt <= (beat_cnt == LAST) ? '0 : beat_cnt + 1'b1;
        if (beat_cnt == '0) bias_q <= bias;
      end
      if (give) begin
        acc_q <= '0;
      end else if (prod_vld_q) begin
        acc_q <= add_sum;
      end
      out_valid_q <= (state == OUTPUT) && !give;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ACCUM: begin
        if (take && beat_cnt == LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        state_nxt = OUTPUT;
      end
      OUTPUT: begin
        if (give) state_nxt = ACCUM;
      end
      default: begin
        state_nxt = ACCUM;
      end
    endcase
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac (DW=16, NUM_INPUTS=4).
`timescale 1ns/1ps
module tb_neuron_mac;

  localparam int DW = 16;
  localparam int N  = 4;
  localparam int AW = 2 * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] in_weight = '0;
  logic [AW-1:0] bias = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] out_acc;
  logic          out_ovf;

  neuron_mac #(
    .DATA_WIDTH       (DW),
    .WEIGHT_INT_WIDTH (4),
    .NUM_INPUTS       (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_weight (in_weight),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] acc;
    logic          ovf;
  } exp_t;

  typedef logic [DW-1:0] beat_arr_t [N];

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_acc_cyc = 0;
  int   bubble_pct = 0;
  int   ready_mode = 0;
  int   stall_left = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: exact integer sum in window order, clamped per add when saturating.
  function automatic exp_t model(input beat_arr_t d, input beat_arr_t w,
                                 input logic [AW-1:0] b);
    exp_t   e;
    longint s;
    longint mx;
    longint mn;
    mx    = (longint'(1) << (AW - 1)) - 1;
    mn    = -mx - 1;
    s     = longint'($signed(b));
    e.ovf = 1'b0;
    for (int i = 0; i < N; i++) begin
      s = s + longint'($signed(d[i])) * longint'($signed(w[i]));
`ifdef NEURON_MAC_SAT_EN
      if (s > mx) begin
        s = mx;
        e.ovf = 1'b1;
      end else if (s < mn) begin
        s = mn;
        e.ovf = 1'b1;
      end
`endif
    end
    if (mx < mn) e.ovf = 1'bx;
    e.acc = s[AW-1:0];
    return e;
  endfunction

  task automatic send_window(input beat_arr_t d, input beat_arr_t w,
                             input logic [AW-1:0] b, input int beats);
    int   i = 0;
    int   guard = 0;
    logic took;
    while (i < beats && guard < 500) begin
      in_valid  = ($urandom_range(99) >= bubble_pct);
      in_data   = d[i];
      in_weight = w[i];
      bias      = (i == 0) ? b : AW'($urandom);
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk);
      #1;
      guard++;
      if (took) begin
        i++;
        if (i == N) begin
          exp_q.push_back(model(d, w, b));
          last_acc_cyc = cyc;
        end
      end
    end
    in_valid = 1'b0;
    chk("beats_sent", 64'(i), 64'(beats));
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((exp_q.size() != 0 || out_valid) && g < 300) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("drain_done", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic fill(output beat_arr_t a, input logic [DW-1:0] v);
    for (int i = 0; i < N; i++) a[i] = v;
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(1));
      default: begin
        if (out_valid && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
        end
      end
    endcase
  end

  logic          prev_v = 1'b0;
  logic          prev_give = 1'b0;
  logic          held = 1'b0;
  logic [AW-1:0] held_acc;
  logic          held_ovf;
  exp_t          e_pop;

  always @(negedge clk) begin
    if (rst) begin
      prev_v    = 1'b0;
      prev_give = 1'b0;
      held      = 1'b0;
    end else begin
      if (prev_give) begin
        chk("valid_drops", 64'(out_valid), 64'(0));
        chk("ready_returns", 64'(in_ready), 64'(1));
        chk("acc_cleared", 64'(out_acc), 64'(0));
      end
      prev_give = 1'b0;
      if (out_valid) begin
        chk("in_ready_low", 64'(in_ready), 64'(0));
        if (!prev_v) chk("latency", 64'(cyc - last_acc_cyc), 64'(2));
        if (held) begin
          chk("stable_acc", 64'(out_acc), 64'(held_acc));
          chk("stable_ovf", 64'(out_ovf), 64'(held_ovf));
        end
        if (out_ready) begin
          chk("exp_available", 64'(exp_q.size() > 0), 64'(1));
          if (exp_q.size() > 0) begin
            e_pop = exp_q.pop_front();
            chk("out_acc", 64'(out_acc), 64'(e_pop.acc));
            chk("out_ovf", 64'(out_ovf), 64'(e_pop.ovf));
          end
          held      = 1'b0;
          prev_give = 1'b1;
        end else begin
          held     = 1'b1;
          held_acc = out_acc;
          held_ovf = out_ovf;
        end
      end else begin
        held = 1'b0;
      end
      prev_v = out_valid;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout required finish");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  beat_arr_t d;
  beat_arr_t w;

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_acc", 64'(out_acc), 64'(0));
    chk("rst_out_ovf", 64'(out_ovf), 64'(0));
    chk("rst_in_ready_after", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;

    fill(d, 16'd2);
    fill(w, 16'd3);
    send_window(d, w, 32'd10, N);
    wait_idle();

    fill(d, 16'hFFFF);
    fill(w, 16'd5);
    send_window(d, w, 32'd0, N);
    wait_idle();

    ready_mode = 2;
    stall_left = 5;
    fill(d, 16'd2);
    fill(w, 16'd3);
    send_window(d, w, 32'd10, N);
    send_window(d, w, 32'd10, N);
    wait_idle();
    ready_mode = 0;

    fill(d, 16'd7);
    fill(w, 16'd9);
    send_window(d, w, 32'd100, 2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    fill(d, 16'd1);
    fill(w, 16'd1);
    send_window(d, w, 32'd0, N);
    wait_idle();

    bubble_pct = 50;
    fill(d, 16'd2);
    fill(w, 16'd3);
    send_window(d, w, 32'd10, N);
    wait_idle();
    bubble_pct = 0;

    fill(d, 16'h7FFF);
    fill(w, 16'h7FFF);
    send_window(d, w, 32'h7FFFFFFF, N);
    wait_idle();

    ready_mode = 1;
    for (int k = 0; k < 20; k++) begin
      bubble_pct = $urandom_range(60);
      for (int i = 0; i < N; i++) begin
        d[i] = DW'($urandom);
        w[i] = DW'($urandom);
      end
      send_window(d, w, AW'($urandom), N);
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
